// File: rtl/debounce_array.sv
// N-channel push-button conditioner: 2-flop sync, per-channel debounce,
// press/release edge pulses, auto-repeat schedule and long-press flag.
module debounce_array #(
  parameter int N_CH           = 5,
  parameter int N_DC           = 15,
  parameter int RPT_DELAY_CYC  = 25_000_000,
  parameter int RPT_PERIOD_CYC = 10_000_000,
  parameter int LONG_CYC       = 100_000_000
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [N_CH-1:0] pb,
  input  logic [N_CH-1:0] rpt_en,
  output logic [N_CH-1:0] dpb,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_evt,  // "release" is a reserved word
  output logic [N_CH-1:0] rpt,
  output logic [N_CH-1:0] long
);

  localparam int HW   = $clog2(LONG_CYC + 1);
  localparam int PMAX = (RPT_DELAY_CYC > RPT_PERIOD_CYC) ? RPT_DELAY_CYC : RPT_PERIOD_CYC;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [N_DC-1:0] DC_MAX   = '1;
  localparam logic [HW-1:0]   LONG_V   = HW'(LONG_CYC);
  localparam logic [HW-1:0]   LONG_M1  = HW'(LONG_CYC - 1);
  localparam logic [PW-1:0]   DELAY_V  = PW'(RPT_DELAY_CYC);
  localparam logic [PW-1:0]   PERIOD_V = PW'(RPT_PERIOD_CYC);
  localparam logic [PW-1:0]   PER_ONE  = PW'(1);

  logic [N_CH-1:0] sync1;
  logic [N_CH-1:0] sync2;
  logic [N_CH-1:0] flip;
  logic [N_DC-1:0] dc_cnt   [N_CH];
  logic [HW-1:0]   hold_cnt [N_CH];
  logic [PW-1:0]   per_cnt  [N_CH];

  // Debounced level changes on this edge.
  always_comb begin
    flip = '0;
    for (int i = 0; i < N_CH; i++) begin
      flip[i] = (sync2[i] != dpb[i]) && (dc_cnt[i] == DC_MAX);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1       <= '0;
      sync2       <= '0;
      dpb         <= '0;
      press       <= '0;
      release_evt <= '0;
      rpt         <= '0;
      long        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        dc_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
        per_cnt[i]  <= '0;
      end
    end else begin
      sync1 <= pb;
      sync2 <= sync1;
      for (int i = 0; i < N_CH; i++) begin
        press[i]       <= 1'b0;
        release_evt[i] <= 1'b0;
        rpt[i]         <= 1'b0;

        if (sync2[i] == dpb[i] || flip[i]) begin
          dc_cnt[i] <= '0;
        end else begin
          dc_cnt[i] <= dc_cnt[i] + 1'b1;
        end

        if (flip[i]) begin
          dpb[i]         <= sync2[i];
          press[i]       <= sync2[i];
          release_evt[i] <= ~sync2[i];
        end

        if (flip[i] && !dpb[i]) begin
          // press cycle is h = 0; the first repeat lands RPT_DELAY_CYC later
          hold_cnt[i] <= '0;
          per_cnt[i]  <= DELAY_V;
          rpt[i]      <= 1'b1;
          long[i]     <= 1'b0;
        end else if (dpb[i] && !flip[i]) begin
          if (hold_cnt[i] != LONG_V) begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end
          long[i] <= long[i] | (hold_cnt[i] == LONG_M1);
          // schedule advances regardless of rpt_en; enable only gates the pulse
          if (per_cnt[i] == PER_ONE) begin
            per_cnt[i] <= PERIOD_V;
            rpt[i]     <= rpt_en[i];
          end else begin
            per_cnt[i] <= per_cnt[i] - 1'b1;
          end
        end else begin
          hold_cnt[i] <= '0;
          per_cnt[i]  <= '0;
          long[i]     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_array.sv
// Directed scenarios plus random button traffic for debounce_array, checked
// every cycle against a history-window / hold-index reference model.
module tb_debounce_array;

  localparam int N_CH = 5;
  localparam int N_DC = 3;
  localparam int D    = 20;
  localparam int P    = 5;
  localparam int LG   = 40;
  localparam int W    = 1 << N_DC;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [N_CH-1:0] pb;
  logic [N_CH-1:0] rpt_en;
  logic [N_CH-1:0] dpb;
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] release_evt;
  logic [N_CH-1:0] rpt;
  logic [N_CH-1:0] long;

  always #5 Clk = ~Clk;

  debounce_array #(
    .N_CH(N_CH), .N_DC(N_DC), .RPT_DELAY_CYC(D), .RPT_PERIOD_CYC(P), .LONG_CYC(LG)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pb(pb), .rpt_en(rpt_en),
    .dpb(dpb), .press(press), .release_evt(release_evt), .rpt(rpt), .long(long)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: raw-input history and hold index per channel.
  logic [N_CH-1:0] m_dpb, m_press, m_rel, m_rpt, m_long;
  logic [W+1:0]    hist [N_CH];
  int              m_h  [N_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // dpb flips once the raw input has held the opposite level for the 2^N_DC
  // cycles ending two cycles before the edge (sync delay).
  task automatic model_edge();
    logic         old_v, new_v;
    logic [W-1:0] win;
    for (int c = 0; c < N_CH; c++) begin
      if (Reset) begin
        hist[c] = '0; m_dpb[c] = 1'b0; m_press[c] = 1'b0; m_rel[c] = 1'b0;
        m_rpt[c] = 1'b0; m_long[c] = 1'b0; m_h[c] = 0;
      end else begin
        old_v   = m_dpb[c];
        hist[c] = {hist[c][W:0], pb[c]};
        win     = hist[c][W+1:2];
        new_v   = old_v ? (win != '0) : (&win);
        m_dpb[c]   = new_v;
        m_press[c] = !old_v && new_v;
        m_rel[c]   = old_v && !new_v;
        if (!old_v && new_v) begin
          m_h[c] = 0; m_rpt[c] = 1'b1; m_long[c] = 1'b0;
        end else if (new_v) begin
          m_h[c]++;
          m_rpt[c]  = rpt_en[c] && (m_h[c] >= D) && ((m_h[c] - D) % P == 0);
          m_long[c] = (m_h[c] >= LG);
        end else begin
          m_h[c] = 0; m_rpt[c] = 1'b0; m_long[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("dpb",     64'(dpb),         64'(m_dpb));
    chk("press",   64'(press),       64'(m_press));
    chk("release", 64'(release_evt), 64'(m_rel));
    chk("rpt",     64'(rpt),         64'(m_rpt));
    chk("long",    64'(long),        64'(m_long));
  endtask

  function automatic logic [63:0] sched(input int en_from, input int last_h);
    logic [63:0] m = '0;
    for (int h = 0; h <= last_h; h++)
      if (h == 0 || (h >= D && (h - D) % P == 0 && h >= en_from)) m[h] = 1'b1;
    return m;
  endfunction

  logic [N_CH-1:0] acc;
  logic [63:0]     mask0, mask4;
  int              lrise, rel4_h;

  initial begin
    Reset = 1'b1; pb = '0; rpt_en = '0;
    repeat (3) step();
    chk("reset_outs", 64'({dpb, press, release_evt, rpt, long}), 64'd0);
    Reset = 1'b0;
    repeat (12) step();

    // clean press on channel 1, repeat disabled
    pb[1] = 1'b1;
    repeat (9) step();
    chk("clean_pre_dpb", 64'(dpb), 64'd0);
    step();
    chk("clean_dpb",   64'(dpb),   64'b00010);
    chk("clean_press", 64'(press), 64'b00010);
    chk("clean_rpt",   64'(rpt),   64'b00010);
    acc = '0;
    repeat (50) begin
      step();
      acc |= press | rpt | release_evt | (dpb & 5'b11101);
    end
    chk("clean_quiet", 64'(acc), 64'd0);
    pb[1] = 1'b0;
    repeat (12) step();

    // bounce on channel 2: 3-cycle runs never debounce
    acc = '0;
    for (int i = 0; i < 30; i++) begin
      pb[2] = ((i / 3) % 2 == 0);
      step();
      acc |= dpb | press;
    end
    chk("bounce_quiet", 64'(acc), 64'd0);
    pb[2] = 1'b1;
    repeat (9) step();
    chk("bounce_pre_dpb", 64'(dpb), 64'd0);
    step();
    chk("bounce_dpb",   64'(dpb),   64'b00100);
    chk("bounce_press", 64'(press), 64'b00100);
    pb[2] = 1'b0;
    repeat (12) step();

    // auto-repeat and long press on channel 0
    rpt_en[0] = 1'b1; pb[0] = 1'b1;
    repeat (10) step();
    mask0 = '0; mask0[0] = rpt[0]; lrise = -1;
    for (int h = 1; h <= 50; h++) begin
      step();
      mask0[h] = rpt[0];
      if (long[0] && lrise < 0) lrise = h;
    end
    chk("ar_rpt_sched", mask0, sched(0, 50));
    chk("ar_long_rise", 64'(lrise), 64'd40);
    pb[0] = 1'b0;
    repeat (9) step();
    chk("ar_pre_release", 64'(release_evt), 64'd0);
    step();
    chk("ar_release",  64'(release_evt), 64'b00001);
    chk("ar_long_low", 64'(long),        64'd0);
    repeat (3) step();

    // repeat masking on channel 3: enable arrives at h = 22
    rpt_en = '0; pb[3] = 1'b1;
    repeat (10) step();
    mask0 = '0; mask0[0] = rpt[3];
    for (int h = 1; h <= 50; h++) begin
      step();
      mask0[h] = rpt[3];
      if (h == 22) rpt_en[3] = 1'b1;
    end
    chk("mask_rpt_sched", mask0, sched(23, 50));
    pb[3] = 1'b0; rpt_en = '0;
    repeat (12) step();

    // simultaneous channels 0 and 4; channel 4 released at h = 27
    rpt_en = 5'b10001; pb = 5'b10001;
    repeat (10) step();
    chk("sim_press", 64'(press), 64'b10001);
    mask0 = '0; mask4 = '0; mask0[0] = rpt[0]; mask4[0] = rpt[4]; rel4_h = -1;
    for (int h = 1; h <= 50; h++) begin
      step();
      mask0[h] = rpt[0];
      mask4[h] = rpt[4];
      if (release_evt[4] && rel4_h < 0) rel4_h = h;
      if (h == 27) pb[4] = 1'b0;
    end
    chk("sim_ch0_sched", mask0, sched(0, 50));
    chk("sim_ch4_sched", mask4, sched(0, 36));
    chk("sim_rel4_h", 64'(rel4_h), 64'd37);
    pb = '0;
    repeat (12) step();

    // reset in the middle of a hold on channel 1
    rpt_en = 5'b00010; pb[1] = 1'b1;
    repeat (10) step();
    repeat (22) step();
    Reset = 1'b1;
    step();
    chk("rst_outs", 64'({dpb, press, release_evt, rpt, long}), 64'd0);
    Reset = 1'b0;
    repeat (9) step();
    chk("rst_pre_dpb", 64'(dpb), 64'd0);
    step();
    chk("rst_press", 64'(press), 64'b00010);
    chk("rst_rpt",   64'(rpt),   64'b00010);
    repeat (20) step();
    chk("rst_rpt_h20", 64'(rpt), 64'b00010);
    pb = '0; rpt_en = '0;
    repeat (12) step();

    // random traffic: fast chatter first, then longer holds
    for (int i = 0; i < 3000; i++) begin
      logic [N_CH-1:0] fl;
      for (int c = 0; c < N_CH; c++)
        fl[c] = ($urandom_range(0, (i < 1500) ? 15 : 63) == 0);
      pb = pb ^ fl;
      if (fl != '0) rpt_en = N_CH'($urandom);
      Reset = ($urandom_range(0, 999) == 0);
      step();
    end
    Reset = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
